lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit in the MEM stage, directly upstream of the word-addressed data `ram`. It turns pipeline load/store requests into RAM `load`/`store` strobes:
- byte/halfword/word loads, with sign/zero extension
- byte/halfword stores, done as read-modify-write, because `ram` writes whole 32-bit words only
- a `stall` to the pipeline while a multi-cycle access is in flight

## Interface
Parameters:
- ADDR_W, 12, RAM word-address width; RAM holds 2^ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle; request fields held stable while `stall`=1.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- stall  out  1  freeze pipeline this cycle.
- rdata  out  32  extended load result.
- rdata_valid  out  1  one-cycle pulse; `rdata` holds the load result.
- access_err  out  1  one-cycle pulse on an illegal or misaligned request.
- data_memory_address  out  ADDR_W  RAM word address = addr[ADDR_W+1:2]; upper bits ignored (aliasing).
- data_memory_data_in  out  32  RAM write data.
- store  out  1  RAM write strobe.
- load  out  1  RAM read strobe.
- data_memory_data_out  in  32  RAM read data; valid in the cycle after `load`=1 with the address held.

## Operation
States: IDLE, LOAD_WAIT, RMW_MERGE, RMW_WRITE.

IDLE, req_valid=1:
- SW: `store`=1, `data_memory_data_in`=wdata, same cycle; `stall`=0; stay IDLE.
- Any load: `load`=1, `stall`=1 → LOAD_WAIT.
- SB/SH: `load`=1, `stall`=1 → RMW_MERGE.
- Illegal request: `access_err`=1, no RAM strobe, `stall`=0, stay IDLE. Illegal means any of:
  - req_load=req_store=1
  - neither req_load nor req_store set
  - unsupported funct3 (loads: 011, 110, 111; stores: anything except 000/001/010)

Per-state behaviour:
- LOAD_WAIT:
  - select lane by addr[1:0]: byte lane addr[1:0]; halfword lane addr[1]
  - extend per funct3 and register into `rdata`; `rdata_valid`=1 next cycle; `stall`=1 this cycle → IDLE.
- RMW_MERGE:
  - register the merged word: read word with the target byte/halfword lane replaced by wdata[7:0] / wdata[15:0]
  - `load`=1 and the same address are held; `stall`=1 → RMW_WRITE.
- RMW_WRITE: `store`=1 with the merged word; `stall`=0 → IDLE.

Outputs:
- `load`/`store` are never both 1.
- `rst`=1 forces `load`=`store`=`stall`=0 combinationally.

## Timing
- Reset values: state IDLE, `rdata`=0, `rdata_valid`=0, `access_err`=0, `stall`=0, `load`=0, `store`=0, `data_memory_data_in`=0.
- SW latency: 0 extra cycles.
- Load:
  - request cycle: `stall`=1
  - LOAD_WAIT cycle: `stall`=1
  - `rdata_valid` on the following cycle, when the pipeline advances.
- SB/SH: 3 cycles; `stall`=1 for the first two; the RAM write happens in the third.
- Reset mid-operation: any state → IDLE on the next edge. A partially complete RMW is abandoned with no write; `rdata_valid` is not issued.
- `req_valid` is ignored outside IDLE.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misaligned requests raise `access_err` for one cycle, with no RAM access and no stall. Misaligned means:
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
- LSU_MISALIGN_CHECK_EN undefined: misalignment is not checked.
  - halfword lane = addr[1]
  - word accesses ignore addr[1:0]
  - `access_err` fires only for illegal requests.

## Test plan
- SW addr 0x1EC, wdata 0x1234_CDEF after reset → same cycle: `store`=1, `data_memory_address`=123, `stall`=0.
- LW 0x1EC → `load`=1, `stall` high 2 cycles, then `rdata`=0x1234_CDEF with `rdata_valid`=1 for exactly one cycle.
- Extension checks on that word:
  - LB 0x1EF → 0x0000_0012
  - LBU 0x1EC → 0x0000_00EF
  - LH 0x1EC → 0xFFFF_CDEF
  - LHU 0x1EC → 0x0000_CDEF
- SB 0xAA at 0x1ED → `stall` 2 cycles, third cycle `store`=1 with 0x1234_AAEF; a following LW returns 0x1234_AAEF.
- LW 0x1EE:
  - with LSU_MISALIGN_CHECK_EN: `access_err` pulse, `load` never asserted
  - without it: word 123 is returned.
- `rst` asserted during RMW_MERGE of SH 0x1EC → `store` never asserted, IDLE next cycle, a later LW returns the unchanged word.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit with extended sub-word loads and read-modify-write byte/halfword stores.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses with access_err.
module lsu_mem_stage #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              access_err,
  output logic [ADDR_W-1:0] data_memory_address,
  output logic [31:0]       data_memory_data_in,
  output logic              store,
  output logic              load,
  input  logic [31:0]       data_memory_data_out
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_MERGE, RMW_WRITE} state_t;
  state_t      r_state;
  logic [31:0] r_rdata;
  logic [31:0] r_merged;
  logic        r_rdata_valid;
  logic        w_req;
  logic        w_ld_ok;
  logic        w_st_ok;
  logic        w_mis;
  logic        w_go;
  logic        w_ld;
  logic        w_sw;
  logic        w_sbh;
  logic        w_unused;
  logic [31:0] w_shift;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_mask;
  logic [31:0] w_wrep;
  logic [31:0] w_merged;
  assign w_req   = req_valid && r_state == IDLE;
  assign w_ld_ok = req_load && !req_store && funct3 != 3'b011 && funct3[2:1] != 2'b11;
  assign w_st_ok = req_store && !req_load && !funct3[2] && funct3[1:0] != 2'b11;
`ifdef LSU_MISALIGN_CHECK_EN
  assign w_mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif
  assign w_go  = w_req && !w_mis;
  assign w_ld  = w_go && w_ld_ok;
  assign w_sw  = w_go && w_st_ok && funct3[1];
  assign w_sbh = w_go && w_st_ok && !funct3[1];
  // Anything the request decode cannot start is reported as an access error.
  assign access_err = !rst && w_req && !(w_ld || w_sw || w_sbh);
  assign load  = !rst && (w_ld || w_sbh || r_state == RMW_MERGE);
  assign store = !rst && (w_sw || r_state == RMW_WRITE);
  assign stall = !rst && (w_ld || w_sbh || r_state == LOAD_WAIT || r_state == RMW_MERGE);
  assign data_memory_address = addr[ADDR_W+1:2];
  assign data_memory_data_in = rst ? '0 : w_sw ? wdata : r_merged;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign w_shift = data_memory_data_out >> {addr[1:0], 3'b000};
  assign w_half  = addr[1] ? data_memory_data_out[31:16] : data_memory_data_out[15:0];
  assign w_ext   = funct3[1] ? data_memory_data_out :
                   funct3[0] ? {{16{!funct3[2] && w_half[15]}}, w_half} :
                               {{24{!funct3[2] && w_shift[7]}}, w_shift[7:0]};
  // Replicate the store data across all lanes, then let the lane mask pick the target.
  assign w_mask   = funct3[0] ? 32'h0000_FFFF << {addr[1], 4'b0000} : 32'h0000_00FF << {addr[1:0], 3'b000};
  assign w_wrep   = funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  assign w_merged = (data_memory_data_out & ~w_mask) | (w_wrep & w_mask);
  assign w_unused = &{1'b0, addr[31:ADDR_W+2], w_shift[31:8]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_merged      <= '0;
    end else begin
      r_rdata_valid <= r_state == LOAD_WAIT;
      if (r_state == LOAD_WAIT) r_rdata <= w_ext;
      if (r_state == RMW_MERGE) r_merged <= w_merged;
      r_state <= r_state == IDLE ? (w_ld ? LOAD_WAIT : w_sbh ? RMW_MERGE : IDLE) :
                 r_state == RMW_MERGE ? RMW_WRITE : IDLE;
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed bench for lsu_mem_stage with a transaction-level memory model,
// a bench-side RAM, a per-cycle compare process and literal pins on key results.
module tb_lsu_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        access_err;
  logic [11:0] dma;
  logic [31:0] din;
  logic        store;
  logic        load;
  logic [31:0] dout = 32'd0;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] ram [4096];
  logic [31:0] mdl [4096];
  logic        clr = 1'b1;
  logic        chk_en = 1'b0;
  logic        exp_ld, exp_st, exp_stall, exp_err, exp_rv, exp_rst;
  logic [11:0] exp_addr;
  logic [31:0] exp_din, exp_rdata;

  always #5 clk = ~clk;

  lsu_mem_stage #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .access_err(access_err), .data_memory_address(dma),
    .data_memory_data_in(din), .store(store), .load(load), .data_memory_data_out(dout)
  );

  // Word-addressed RAM: read data appears the cycle after load, writes land on the edge.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 32'd0;
    end else begin
      if (load) dout <= ram[dma];
      if (store) ram[dma] <= din;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("load", 32'(load), 32'(exp_ld));
      check("store", 32'(store), 32'(exp_st));
      check("stall", 32'(stall), 32'(exp_stall));
      check("access_err", 32'(access_err), 32'(exp_err));
      check("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
      if (exp_ld || exp_st) check("addr", 32'(dma), 32'(exp_addr));
      if (exp_st) check("wr_data", din, exp_din);
      if (exp_rv) check("rdata", rdata, exp_rdata);
      if (exp_rst) begin
        check("rst_rdata", rdata, 32'd0);
        check("rst_din", din, 32'd0);
      end
    end
  end

  task automatic se(input logic l, s, sl, e, r, input logic [31:0] d, rd);
    exp_ld = l; exp_st = s; exp_stall = sl; exp_err = e; exp_rv = r; exp_din = d; exp_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] word, input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*o +: 8];
    h = word[16*o[1] +: 16];
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd4: return {24'd0, b};
      3'd5: return {16'd0, h};
      default: return word;
    endcase
  endfunction

  task automatic txn(input logic ld, st, input logic [2:0] f3, input logic [31:0] a, wd);
    logic        legal, mis;
    logic [11:0] w;
    logic [31:0] m;
    w = a[13:2];
    legal = (ld != st) && (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2}));
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
`endif
    req_valid = 1'b1; req_load = ld; req_store = st; funct3 = f3; addr = a; wdata = wd; exp_addr = w;
    if (!legal || mis) begin
      se(0, 0, 0, 1, 0, 0, 0); tick();
    end else if (st && f3 == 3'd2) begin
      mdl[w] = wd;
      se(0, 1, 0, 0, 0, wd, 0); tick();
    end else if (ld) begin
      se(1, 0, 1, 0, 0, 0, 0); tick();
      se(0, 0, 1, 0, 0, 0, 0); tick();
      req_valid = 1'b0;
      se(0, 0, 0, 0, 1, 0, ld_val(f3, mdl[w], a[1:0])); tick();
    end else begin
      m = mdl[w];
      if (f3 == 3'd0) m[8*a[1:0] +: 8] = wd[7:0];
      else m[16*a[1] +: 16] = wd[15:0];
      mdl[w] = m;
      se(1, 0, 1, 0, 0, 0, 0); tick();
      se(1, 0, 1, 0, 0, 0, 0); tick();
      se(0, 1, 0, 0, 0, m, 0); tick();
    end
    req_valid = 1'b0;
    se(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mdl[i] = 32'd0;
    exp_addr = 12'd0;
    se(0, 0, 0, 0, 0, 0, 0);
    exp_rst = 1'b1;
    tick();
    clr = 1'b0;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_rst = 1'b0;

    txn(0, 1, 3'd2, 32'h1EC, 32'h1234_CDEF);
    check("pin_sw_mdl", mdl[123], 32'h1234_CDEF);
    check("pin_sw_ram", ram[123], 32'h1234_CDEF);
    txn(1, 0, 3'd2, 32'h1EC, 0); check("pin_lw", rdata, 32'h1234_CDEF);
    txn(1, 0, 3'd0, 32'h1EF, 0); check("pin_lb", rdata, 32'h0000_0012);
    txn(1, 0, 3'd4, 32'h1EC, 0); check("pin_lbu", rdata, 32'h0000_00EF);
    txn(1, 0, 3'd1, 32'h1EC, 0); check("pin_lh", rdata, 32'hFFFF_CDEF);
    txn(1, 0, 3'd5, 32'h1EC, 0); check("pin_lhu", rdata, 32'h0000_CDEF);
    txn(0, 1, 3'd0, 32'h1ED, 32'h0000_00AA); check("pin_sb_ram", ram[123], 32'h1234_AAEF);
    txn(1, 0, 3'd2, 32'h1EC, 0); check("pin_lw_sb", rdata, 32'h1234_AAEF);
    txn(1, 0, 3'd2, 32'h1EE, 0);
`ifndef LSU_MISALIGN_CHECK_EN
    check("pin_lw_unaligned", rdata, 32'h1234_AAEF);
`endif
    txn(0, 1, 3'd1, 32'h1EE, 32'h7777_BEEF); check("pin_sh_ram", ram[123], 32'hBEEF_AAEF);
    txn(1, 0, 3'd1, 32'h1EE, 0); check("pin_lh_hi", rdata, 32'hFFFF_BEEF);
    txn(1, 0, 3'd4, 32'h1ED, 0); check("pin_lbu_1", rdata, 32'h0000_00AA);
    txn(1, 0, 3'd0, 32'h1EE, 0); check("pin_lb_2", rdata, 32'hFFFF_FFEF);
    txn(1, 0, 3'd5, 32'h1ED, 0);

    // Reset lands during RMW_MERGE of SH 0x1EC: the write must be abandoned.
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; funct3 = 3'd1; addr = 32'h1EC; wdata = 32'h5555;
    exp_addr = 12'd123;
    se(1, 0, 1, 0, 0, 0, 0); tick();
    rst = 1'b1;
    se(0, 0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0; req_valid = 1'b0; exp_rst = 1'b1;
    tick();
    exp_rst = 1'b0;
    check("pin_rst_ram", ram[123], 32'hBEEF_AAEF);
    txn(1, 0, 3'd2, 32'h1EC, 0); check("pin_lw_rst", rdata, 32'hBEEF_AAEF);

    txn(0, 1, 3'd2, 32'h0001_01EC, 32'hCAFE_F00D);
    txn(1, 0, 3'd2, 32'h1EC, 0); check("pin_alias", rdata, 32'hCAFE_F00D);

    txn(1, 1, 3'd2, 32'h1EC, 0);
    txn(0, 0, 3'd2, 32'h1EC, 0);
    txn(1, 0, 3'd3, 32'h1EC, 0);
    txn(1, 0, 3'd6, 32'h1EC, 0);
    txn(0, 1, 3'd4, 32'h1EC, 32'h1);
    txn(0, 1, 3'd1, 32'h1ED, 32'h1234);
    txn(0, 1, 3'd2, 32'h1E2, 32'h1111_2222);
    txn(1, 0, 3'd2, 32'h1E0, 0);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
